// File: rtl/led_sequence_player_pkg.sv
// Shared types and constants for the LED sequence player.
// State encoding, LED bank width and fixed patterns.
package led_seq_pkg;

  localparam int LED_W = 5;

  typedef enum logic [1:0] {
    IDLE,
    SWEEP_R,
    SWEEP_L,
    BLINK
  } led_seq_state_t;

  localparam logic [LED_W-1:0] LED_ALL_ON  = '1;
  localparam logic [LED_W-1:0] LED_ALL_OFF = '0;
  localparam logic [LED_W-1:0] LED_FIRST   = 5'b00001;
  localparam logic [LED_W-1:0] LED_TURN    = 5'b01000;

endpackage

// File: rtl/led_sequence_player_if.sv
// Trigger/status bundle between the requester and the player.
// The player sits on the slave side and drives the LED/status lines.
interface led_sequence_player_if;
  import led_seq_pkg::*;

  logic             trigger;
  logic [LED_W-1:0] led;
  logic             busy;
  logic             done;

  modport master (
    output trigger,
    input  led,
    input  busy,
    input  done
  );

  modport slave (
    input  trigger,
    output led,
    output busy,
    output done
  );

endinterface

// File: rtl/led_sequence_player_step_timer.sv
// Animation step timer: counts 0..TICK_DIV-1 while enabled.
// tick is high during the terminal count so the next edge advances.
module step_timer #(
  parameter int TICK_DIV = 12_500_000
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt;

  assign tick = en && (cnt == LAST);

  // free-running step count, restarted when a sequence begins
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt <= '0;
    end else if (clr) begin
      cnt <= '0;
    end else if (en) begin
      cnt <= tick ? '0 : cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_sequence_player.sv
// Plays right sweep, left sweep, then blinks on a trigger rise.
// Start events while a sequence is running are dropped.
module led_sequence_player #(
  parameter int TICK_DIV    = 12_500_000,
  parameter int BLINK_PAIRS = 3
) (
  input logic                  clk,
  input logic                  reset,
  led_sequence_player_if.slave bus
);
  import led_seq_pkg::*;

  localparam int BLINK_N = 2 * BLINK_PAIRS;
  localparam int IDX_N   = (BLINK_N > 5) ? BLINK_N : 5;
  localparam int IW      = $clog2(IDX_N);

  localparam logic [IW-1:0] R_LAST = IW'(4);
  localparam logic [IW-1:0] L_LAST = IW'(3);
  localparam logic [IW-1:0] B_LAST = IW'(BLINK_N - 1);

  led_seq_state_t   state;
  logic [IW-1:0]    idx;
  logic [LED_W-1:0] led_q;
  logic             busy_q;
  logic             done_q;
  logic             trig_q;
  logic             armed;
  logic             rise;
  logic             go;
  logic             tick;

  assign rise = bus.trigger & ~trig_q & armed;
  assign go   = rise && (state == IDLE);

  // trigger history; armed keeps a level held through reset from starting
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      trig_q <= 1'b0;
      armed  <= 1'b0;
    end else begin
      trig_q <= bus.trigger;
      armed  <= 1'b1;
    end
  end

  step_timer #(
    .TICK_DIV (TICK_DIV)
  ) u_timer (
    .clk   (clk),
    .reset (reset),
    .clr   (go),
    .en    (busy_q),
    .tick  (tick)
  );

  // sequence FSM with step index and registered LED pattern
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= IDLE;
      idx    <= '0;
      led_q  <= LED_ALL_OFF;
      busy_q <= 1'b0;
      done_q <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state)
        IDLE: begin
          if (go) begin
            state  <= SWEEP_R;
            idx    <= '0;
            led_q  <= LED_FIRST;
            busy_q <= 1'b1;
          end
        end
        SWEEP_R: begin
          if (tick) begin
            if (idx == R_LAST) begin
              state <= SWEEP_L;
              idx   <= '0;
              led_q <= LED_TURN;
            end else begin
              idx   <= idx + 1'b1;
              led_q <= led_q << 1;
            end
          end
        end
        SWEEP_L: begin
          if (tick) begin
            if (idx == L_LAST) begin
              state <= BLINK;
              idx   <= '0;
              led_q <= LED_ALL_ON;
            end else begin
              idx   <= idx + 1'b1;
              led_q <= led_q >> 1;
            end
          end
        end
        BLINK: begin
          if (tick) begin
            if (idx == B_LAST) begin
              state  <= IDLE;
              idx    <= '0;
              led_q  <= LED_ALL_OFF;
              busy_q <= 1'b0;
              done_q <= 1'b1;
            end else begin
              idx   <= idx + 1'b1;
              led_q <= ~led_q;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign bus.led  = led_q;
  assign bus.busy = busy_q;
  assign bus.done = done_q;

endmodule

// File: tb/tb_led_sequence_player.sv
// Scoreboard bench for led_sequence_player.
// Directed scenarios followed by random trigger/reset traffic.
module tb_led_sequence_player;
  import led_seq_pkg::*;

  localparam int TD    = 4;
  localparam int BP    = 3;
  localparam int NSTEP = 9 + 2 * BP;

  typedef struct packed {
    logic [4:0] led;
    logic       busy;
    logic       done;
  } obs_t;

  logic clk   = 1'b0;
  logic reset = 1'b1;

  led_sequence_player_if bus ();

  led_sequence_player #(
    .TICK_DIV    (TD),
    .BLINK_PAIRS (BP)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  obs_t       exp_q[$];
  int         n_vec   = 0;
  int         n_err   = 0;
  int         edge_n  = 0;
  bit         m_prev  = 1'b1;
  bit         m_play  = 1'b0;
  int         m_start = 0;
  logic [4:0] pat[NSTEP];

  // reference: the show is a table of patterns indexed by elapsed/TD
  task automatic model_edge(input logic tr, input logic rs);
    obs_t o;
    int   el;
    o = '0;
    edge_n++;
    if (rs) begin
      m_play = 1'b0;
      m_prev = 1'b1;
    end else begin
      if (m_play) begin
        el = edge_n - m_start;
        if (el == NSTEP * TD) begin
          m_play = 1'b0;
          o.done = 1'b1;
        end else begin
          o.led  = pat[el / TD];
          o.busy = 1'b1;
        end
      end else if (tr && !m_prev) begin
        m_play  = 1'b1;
        m_start = edge_n;
        o.led   = pat[0];
        o.busy  = 1'b1;
      end
      m_prev = tr;
    end
    exp_q.push_back(o);
  endtask

  task automatic check_now();
    n_vec++;
    if (bus.led !== 5'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      n_err++;
      $display("FAIL async_reset t=%0t: got led=%b busy=%b done=%b want all 0",
               $time, bus.led, bus.busy, bus.done);
    end
  endtask

  task automatic cycle(input logic tr, input logic rs);
    @(negedge clk);
    #1;
    bus.trigger = tr;
    if (rs && !reset) begin
      reset = 1'b1;
      #1;
      check_now();
    end
    reset = rs;
    @(posedge clk);
    model_edge(tr, rs);
  endtask

  task automatic run(input logic tr, input logic rs, input int n);
    for (int i = 0; i < n; i++) cycle(tr, rs);
  endtask

  // monitor: compare every cycle's outputs against the scoreboard
  always @(negedge clk) begin
    obs_t e;
    obs_t a;
    if (exp_q.size() > 0) begin
      e      = exp_q.pop_front();
      a.led  = bus.led;
      a.busy = bus.busy;
      a.done = bus.done;
      n_vec++;
      if (a !== e) begin
        n_err++;
        $display("FAIL outputs edge %0d: got led=%b busy=%b done=%b want led=%b busy=%b done=%b",
                 edge_n, a.led, a.busy, a.done, e.led, e.busy, e.done);
      end
    end
  end

  initial begin
    logic rt;
    logic rr;
    bus.trigger = 1'b0;
    for (int i = 0; i < 5; i++) pat[i] = 5'(1 << i);
    for (int i = 0; i < 4; i++) pat[5 + i] = 5'(8 >> i);
    for (int i = 0; i < 2 * BP; i++) pat[9 + i] = (i % 2 == 0) ? 5'b11111 : 5'b00000;

    run(0, 1, 3);
    run(0, 0, 6);
    run(1, 0, 19);
    run(0, 0, 1);
    run(1, 0, 39);
    run(0, 0, 1);
    run(1, 0, 1);
    run(0, 0, 1);
    run(1, 0, 60);
    run(1, 0, 15);

    run(0, 0, 2);
    run(1, 0, 1);
    run(0, 0, 70);

    run(1, 0, 25);
    run(1, 1, 2);
    run(1, 0, 10);
    run(0, 0, 1);
    run(1, 0, 65);

    rt = 1'b0;
    for (int i = 0; i < 2500; i++) begin
      if ($urandom_range(19, 0) == 0) rt = ~rt;
      rr = ($urandom_range(299, 0) == 0);
      cycle(rt, rr);
    end

    @(negedge clk);
    #2;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
